morse_decoder: RTL and testbench

- Receive-side block that converts a keyed on/off Morse signal into ASCII characters.
- Measures mark (key high) and space (key low) durations against a programmable dot unit and classifies each mark as dot or dash.
- Accumulates up to 4 symbols per character and emits an ASCII code with a 1-cycle valid strobe when a character gap is detected.
- Emits ASCII space (8'h20) on a word gap. Sits between the key/line input and the character sink (UART/display path).

---
 rtl/morse_decoder_if.sv | 28 ++
 rtl/morse_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_morse_decoder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_decoder_if.sv
// Key input and decoded-character output bundle for the Morse decoder.
// Latency: none; this is wiring only.
// Backpressure: none; the sink must take every char_valid strobe as it arrives.
interface morse_decoder_if;
    logic       key_in;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_err;
    logic       busy;

    // Decoder side: samples the key, drives the character stream.
    modport master (
        input  key_in,
        output char_out,
        output char_valid,
        output char_err,
        output busy
    );

    // Key source / character sink side.
    modport slave (
        output key_in,
        input  char_out,
        input  char_valid,
        input  char_err,
        input  busy
    );
endinterface

// File: rtl/morse_decoder.sv
// Decodes a keyed on/off Morse line into ASCII characters plus word spaces.
// Latency: strobe 1 cycle after the gap counter hits its threshold, 2 extra cycles of sync.
// Backpressure: none; char_valid is a 1-cycle strobe, char_out/char_err hold until the next one.
module morse_decoder #(
    parameter int UNIT_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    morse_decoder_if.master bus
);

    localparam logic [CNT_W-1:0] GLITCH_TH = CNT_W'(UNIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] DASH_TH   = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_TH   = CNT_W'(5 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_GAP,
        ST_SPACE
    } state_t;

    // Two-flop synchronizer plus one delayed copy of key_s for edge detection.
    logic             key_m_q;
    logic             key_s_q;
    logic             key_d_q;

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [3:0]       pattern_q,    pattern_d;
    logic [2:0]       len_q,        len_d;
    logic             ovf_q,        ovf_d;
    logic [7:0]       char_out_q,   char_out_d;
    logic             char_valid_q, char_valid_d;
    logic             char_err_q,   char_err_d;
    logic             busy_q,       busy_d;

    logic             key_edge;
    logic             key_fall;
    logic             sym;
    logic [8:0]       decoded;

    // Maps the accumulated symbols to {err, ascii}; unknown patterns and overflow give '?'.
    function automatic logic [8:0] decode(input logic [2:0] len,
                                          input logic [3:0] pat,
                                          input logic       ovf);
        logic [7:0] c;
        c = 8'h00;
        case ({len, pat})
            7'b001_0000: c = "E";
            7'b001_0001: c = "T";
            7'b010_0000: c = "I";
            7'b010_0001: c = "A";
            7'b010_0010: c = "N";
            7'b010_0011: c = "M";
            7'b011_0000: c = "S";
            7'b011_0001: c = "U";
            7'b011_0010: c = "R";
            7'b011_0011: c = "W";
            7'b011_0100: c = "D";
            7'b011_0101: c = "K";
            7'b011_0110: c = "G";
            7'b011_0111: c = "O";
            7'b100_0000: c = "H";
            7'b100_0001: c = "V";
            7'b100_0010: c = "F";
            7'b100_0100: c = "L";
            7'b100_0110: c = "P";
            7'b100_0111: c = "J";
            7'b100_1000: c = "B";
            7'b100_1001: c = "X";
            7'b100_1010: c = "C";
            7'b100_1011: c = "Y";
            7'b100_1100: c = "Z";
            7'b100_1101: c = "Q";
            default:     c = 8'h00;
        endcase
        if (ovf || (c == 8'h00)) begin
            return {1'b1, 8'h3F};
        end
        return {1'b0, c};
    endfunction

    // Next-state logic: duration counter, symbol accumulation and character emission.
    always_comb begin
        key_edge = key_s_q ^ key_d_q;
        key_fall = key_d_q & ~key_s_q;
        sym      = (cnt_q >= DASH_TH);
        decoded  = decode(len_q, pattern_q, ovf_q);

        // Counter restarts on every key edge so cnt always measures the current run.
        if (key_edge) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        state_d      = state_q;
        pattern_d    = pattern_q;
        len_d        = len_q;
        ovf_d        = ovf_q;
        char_out_d   = char_out_q;
        char_err_d   = char_err_q;
        char_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_s_q) begin
                    state_d = ST_MARK;
                end
            end
            ST_MARK: begin
                if (key_fall) begin
                    if (cnt_q < GLITCH_TH) begin
                        // Too short to be a symbol: drop it, keep whatever was pending.
                        state_d = (len_q != 3'd0) ? ST_GAP : ST_IDLE;
                    end else begin
                        if (len_q == 3'd4) begin
                            ovf_d = 1'b1;
                        end else begin
                            pattern_d = {pattern_q[2:0], sym};
                            len_d     = len_q + 3'd1;
                        end
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // Threshold wins over a coincident new mark so a gap of exactly 2 units splits.
                if (cnt_q == DASH_TH) begin
                    char_valid_d = 1'b1;
                    char_out_d   = decoded[7:0];
                    char_err_d   = decoded[8];
                    pattern_d    = 4'd0;
                    len_d        = 3'd0;
                    ovf_d        = 1'b0;
                    state_d      = key_s_q ? ST_MARK : ST_SPACE;
                end else if (key_s_q) begin
                    state_d = ST_MARK;
                end
            end
            ST_SPACE: begin
                if (key_s_q) begin
                    state_d = ST_MARK;
                end else if (cnt_q == WORD_TH) begin
                    char_valid_d = 1'b1;
                    char_out_d   = 8'h20;
                    char_err_d   = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // All state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_m_q      <= 1'b0;
            key_s_q      <= 1'b0;
            key_d_q      <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pattern_q    <= 4'd0;
            len_q        <= 3'd0;
            ovf_q        <= 1'b0;
            char_out_q   <= 8'h00;
            char_valid_q <= 1'b0;
            char_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            key_m_q      <= bus.key_in;
            key_s_q      <= key_m_q;
            key_d_q      <= key_s_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pattern_q    <= pattern_d;
            len_q        <= len_d;
            ovf_q        <= ovf_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            char_err_q   <= char_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.char_out   = char_out_q;
    assign bus.char_valid = char_valid_q;
    assign bus.char_err   = char_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder with UNIT_CYCLES=4.
// Directed scenarios use fixed expected characters; random key traffic uses a string-level model.
// The sink never stalls; every strobe is captured on the falling clock edge.
module tb_morse_decoder;
    localparam int U = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    morse_decoder_if bus();

    morse_decoder #(.UNIT_CYCLES(U), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] obs_q[$];
    logic       seg_lvl[$];
    int         seg_len[$];
    logic [8:0] exp_q[$];
    int         strobe_run = 0;
    int         max_run    = 0;

    string morse_tbl [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                              ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                              "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    // Capture every strobe as {err, char} and track the longest run of consecutive valid cycles.
    always @(negedge clk) begin
        if (bus.char_valid === 1'b1) begin
            obs_q.push_back({bus.char_err, bus.char_out});
            strobe_run = strobe_run + 1;
            if (strobe_run > max_run) max_run = strobe_run;
        end else begin
            strobe_run = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Hold key_in at lvl for n clock cycles and record the run for the model.
    task automatic seg(input logic lvl, input int n);
        if ((seg_lvl.size() > 0) && (seg_lvl[seg_lvl.size()-1] == lvl))
            seg_len[seg_len.size()-1] = seg_len[seg_len.size()-1] + n;
        else begin
            seg_lvl.push_back(lvl);
            seg_len.push_back(n);
        end
        bus.key_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_scenario();
        obs_q.delete();
        seg_lvl.delete();
        seg_len.delete();
    endtask

    function automatic logic [8:0] model_char(input string s, input bit ovf);
        if (ovf) return {1'b1, 8'h3F};
        for (int k = 0; k < 26; k++)
            if (morse_tbl[k] == s) return {1'b0, 8'(65 + k)};
        return {1'b1, 8'h3F};
    endfunction

    // Reference: walk the recorded mark/space runs and apply the timing rules directly.
    task automatic build_expected();
        string s;
        bit    ovf;
        bit    armed;
        exp_q.delete();
        s = "";
        ovf = 1'b0;
        armed = 1'b0;
        for (int i = 0; i < seg_lvl.size(); i++) begin
            if (seg_lvl[i]) begin
                armed = 1'b0;
                if (seg_len[i] >= U / 2) begin
                    if (s.len() == 4) ovf = 1'b1;
                    else if (seg_len[i] >= 2 * U) s = {s, "-"};
                    else s = {s, "."};
                end
            end else begin
                if ((s.len() > 0) && (seg_len[i] >= 2 * U)) begin
                    exp_q.push_back(model_char(s, ovf));
                    s = "";
                    ovf = 1'b0;
                    armed = 1'b1;
                end
                if (armed && (seg_len[i] > 5 * U)) begin
                    exp_q.push_back(9'h020);
                    armed = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.key_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.char_out !== 8'h00) $display("FAIL reset_char_out: got %h want 00", bus.char_out); else n_pass++;
        n_checks++; if (bus.char_valid !== 1'b0) $display("FAIL reset_char_valid: got %b want 0", bus.char_valid); else n_pass++;
        n_checks++; if (bus.char_err !== 1'b0) $display("FAIL reset_char_err: got %b want 0", bus.char_err); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        rst_n = 1'b1;
        start_scenario();
        seg(1'b0, 40);
        n_checks++; if (obs_q.size() != 0) $display("FAIL idle_no_strobe: got %0d strobes want 0", obs_q.size()); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_letter_a();
        int n;
        start_scenario();
        seg(1'b1, 4);
        seg(1'b0, 4);
        seg(1'b1, 12);
        bus.key_in = 1'b0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.char_valid === 1'b1) break;
        end
        n_checks++; if (n != 11) $display("FAIL a_latency: got %0d cycles want 11", n); else n_pass++;
        n_checks++; if (bus.char_out !== 8'h41) $display("FAIL a_char: got %h want 41", bus.char_out); else n_pass++;
        n_checks++; if (bus.char_err !== 1'b0) $display("FAIL a_err: got %b want 0", bus.char_err); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (bus.char_valid !== 1'b0) $display("FAIL a_single_cycle: got %b want 0", bus.char_valid); else n_pass++;
        n_checks++; if (bus.char_out !== 8'h41) $display("FAIL a_hold: got %h want 41", bus.char_out); else n_pass++;
        @(negedge clk);
        seg(1'b0, 30);
        n_checks++; if (obs_q.size() != 2) $display("FAIL a_count: got %0d want 2", obs_q.size());
        else if (obs_q[1] !== 9'h020) $display("FAIL a_space: got %h want 020", obs_q[1]);
        else n_pass++;
    endtask

    task automatic test_sos();
        logic [8:0] exp_sos [4] = '{9'h053, 9'h04F, 9'h053, 9'h020};
        start_scenario();
        for (int i = 0; i < 3; i++) begin seg(1'b1, 4);  seg(1'b0, (i == 2) ? 12 : 4); end
        for (int i = 0; i < 3; i++) begin seg(1'b1, 12); seg(1'b0, (i == 2) ? 12 : 4); end
        for (int i = 0; i < 3; i++) begin seg(1'b1, 4);  seg(1'b0, (i == 2) ? 24 : 4); end
        n_checks++;
        if (obs_q.size() != 4) $display("FAIL sos_count: got %0d want 4", obs_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (obs_q[i] !== exp_sos[i]) $display("FAIL sos_char%0d: got %h want %h", i, obs_q[i], exp_sos[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_glitch();
        start_scenario();
        seg(1'b1, 4);
        seg(1'b0, 2);
        seg(1'b1, 1);
        seg(1'b0, 30);
        n_checks++;
        if (obs_q.size() != 2) $display("FAIL glitch_count: got %0d want 2", obs_q.size());
        else if (obs_q[0] !== 9'h045) $display("FAIL glitch_char: got %h want 045", obs_q[0]);
        else n_pass++;
    endtask

    task automatic test_overflow();
        start_scenario();
        for (int i = 0; i < 5; i++) begin seg(1'b1, 4); seg(1'b0, (i == 4) ? 30 : 4); end
        seg(1'b1, 4);  seg(1'b0, 4);
        seg(1'b1, 4);  seg(1'b0, 4);
        seg(1'b1, 12); seg(1'b0, 4);
        seg(1'b1, 12); seg(1'b0, 30);
        n_checks++;
        if (obs_q.size() != 4) $display("FAIL ovf_count: got %0d want 4", obs_q.size());
        else begin
            n_pass++;
            n_checks++; if (obs_q[0] !== 9'h13F) $display("FAIL ovf_five_dots: got %h want 13F", obs_q[0]); else n_pass++;
            n_checks++; if (obs_q[2] !== 9'h13F) $display("FAIL ovf_invalid: got %h want 13F", obs_q[2]); else n_pass++;
        end
    endtask

    task automatic test_thresholds();
        logic [8:0] exp_th [11] = '{9'h045, 9'h020, 9'h054, 9'h020, 9'h049, 9'h020,
                                    9'h045, 9'h045, 9'h020, 9'h045, 9'h020};
        start_scenario();
        seg(1'b1, 7); seg(1'b0, 30);
        seg(1'b1, 8); seg(1'b0, 30);
        seg(1'b1, 4); seg(1'b0, 7); seg(1'b1, 4); seg(1'b0, 30);
        seg(1'b1, 4); seg(1'b0, 8); seg(1'b1, 4); seg(1'b0, 30);
        seg(1'b1, 2); seg(1'b0, 30);
        n_checks++;
        if (obs_q.size() != 11) $display("FAIL thr_count: got %0d want 11", obs_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if (obs_q[i] !== exp_th[i]) $display("FAIL thr_char%0d: got %h want %h", i, obs_q[i], exp_th[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        start_scenario();
        seg(1'b1, 12);
        seg(1'b0, 4);
        seg(1'b1, 2);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", bus.busy); else n_pass++;
        rst_n = 1'b0;
        #2;
        n_checks++; if (bus.char_out !== 8'h00) $display("FAIL mid_char_out: got %h want 00", bus.char_out); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.char_valid !== 1'b0 || bus.char_err !== 1'b0)
            $display("FAIL mid_flags: got valid %b err %b want 0 0", bus.char_valid, bus.char_err); else n_pass++;
        bus.key_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (obs_q.size() != 0) $display("FAIL mid_no_strobe: got %0d want 0", obs_q.size()); else n_pass++;
        seg(1'b0, 10);
        seg(1'b1, 4);
        seg(1'b0, 30);
        n_checks++;
        if (obs_q.size() != 2) $display("FAIL mid_count: got %0d want 2", obs_q.size());
        else if (obs_q[0] !== 9'h045) $display("FAIL mid_clean_e: got %h want 045", obs_q[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        int m;
        int g;
        start_scenario();
        seg(1'b0, 5);
        for (int i = 0; i < 200; i++) begin
            m = $urandom_range(1, 16);
            g = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 7) : $urandom_range(8, 30);
            if (g == 20) g = 21;
            seg(1'b1, m);
            seg(1'b0, g);
        end
        seg(1'b0, 30);
        build_expected();
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; (i < obs_q.size()) && (i < exp_q.size()); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL rand_char%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_strobe_width();
        n_checks++;
        if (max_run != 1) $display("FAIL strobe_width: got %0d cycles want 1", max_run);
        else n_pass++;
    endtask

    initial begin
        bus.key_in = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_letter_a();
        test_sos();
        test_glitch();
        test_overflow();
        test_thresholds();
        test_reset_mid();
        test_random();
        test_strobe_width();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
